// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// the grant-select constants used by the round-robin selector.
package fifo_wr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_A    = 2'd1,
      ST_WR_B_LO = 2'd2,
      ST_WR_B_HI = 2'd3
   } state_t;

   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter_rr_sel.sv
// Two-way round-robin selector: on a tie, grants the requester that was not
// granted last; otherwise grants whichever requester is active.
module fifo_wr_rr_sel
   import fifo_wr_arbiter_pkg::*;
(
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_last_gnt,
   output logic o_gnt,
   output logic o_gnt_vld
);

   always_comb begin
      o_gnt_vld = i_req_a | i_req_b;
      o_gnt     = GNT_A;
      if (i_req_a && i_req_b) begin
         o_gnt = (i_last_gnt == GNT_B) ? GNT_A : GNT_B;
      end else if (i_req_b) begin
         o_gnt = GNT_B;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates a byte requester (A) and a double-width requester (B) onto a
// single FIFO write port; B words are written LSB first, never interleaved.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_a,
   input  logic [DATA_WIDTH-1:0]   i_data_a,
   input  logic                    i_req_b,
   input  logic [2*DATA_WIDTH-1:0] i_data_b,
   input  logic                    i_full,
   output logic                    o_ack_a,
   output logic                    o_ack_b,
   output logic [DATA_WIDTH-1:0]   o_wr_data,
   output logic                    o_w_inc,
   output logic                    o_busy
);

   state_t                  r_state;
   logic                    r_last_gnt;
   logic                    r_ack_a;
   logic                    r_ack_b;
   logic [DATA_WIDTH-1:0]   r_wr_data;
   logic [DATA_WIDTH-1:0]   r_cap_hi;
   logic                    w_gnt;
   logic                    w_gnt_vld;

   fifo_wr_rr_sel u_rr_sel (
      .i_req_a    (i_req_a),
      .i_req_b    (i_req_b),
      .i_last_gnt (r_last_gnt),
      .o_gnt      (w_gnt),
      .o_gnt_vld  (w_gnt_vld)
   );

   // The MSB half of a B word waits in r_cap_hi while the LSB is on the port.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= GNT_B;
         r_ack_a    <= 1'b0;
         r_ack_b    <= 1'b0;
         r_wr_data  <= '0;
         r_cap_hi   <= '0;
      end else begin
         r_ack_a <= 1'b0;
         r_ack_b <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_last_gnt <= w_gnt;
                  if (w_gnt == GNT_A) begin
                     r_wr_data <= i_data_a;
                     r_ack_a   <= 1'b1;
                     r_state   <= ST_WR_A;
                  end else begin
                     r_wr_data <= i_data_b[DATA_WIDTH-1:0];
                     r_cap_hi  <= i_data_b[2*DATA_WIDTH-1:DATA_WIDTH];
                     r_ack_b   <= 1'b1;
                     r_state   <= ST_WR_B_LO;
                  end
               end
            end
            ST_WR_A: begin
               if (!i_full) r_state <= ST_IDLE;
            end
            ST_WR_B_LO: begin
               if (!i_full) begin
                  r_wr_data <= r_cap_hi;
                  r_state   <= ST_WR_B_HI;
               end
            end
            ST_WR_B_HI: begin
               if (!i_full) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_w_inc   = (r_state != ST_IDLE) && !i_full;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_ack_a   = r_ack_a;
   assign o_ack_b   = r_ack_b;
   assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based model of the FIFO byte stream.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          reqA = 1'b0;
   logic          reqB = 1'b0;
   logic          full = 1'b0;
   logic [DW-1:0] dataA = '0;
   logic [2*DW-1:0] dataB = '0;
   logic          ackA, ackB, wInc, busy;
   logic [DW-1:0] wrData;

   int checks = 0;
   int failures = 0;

   logic [7:0]  srcA[$];
   logic [15:0] srcB[$];
   logic [7:0]  pend[$];
   logic [7:0]  wrLog[$];
   logic [7:0]  expLog[$];
   logic        lastB = 1'b1;
   logic        expAckA = 1'b0;
   logic        expAckB = 1'b0;
   logic        randFull = 1'b0;
   logic        fullVal = 1'b0;

   fifo_wr_arbiter #(.DATA_WIDTH(DW)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_req_a   (reqA),
      .i_data_a  (dataA),
      .i_req_b   (reqB),
      .i_data_b  (dataB),
      .i_full    (full),
      .o_ack_a   (ackA),
      .o_ack_b   (ackB),
      .o_wr_data (wrData),
      .o_w_inc   (wInc),
      .o_busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic checkLog(input string tag);
      checkOutput({tag, "_len"}, wrLog.size(), expLog.size());
      for (int i = 0; i < wrLog.size() && i < expLog.size(); i++)
         checkOutput($sformatf("%s_byte%0d", tag, i), wrLog[i], expLog[i]);
      wrLog.delete();
   endtask

   // One clock: requesters react to ACK, outputs are checked against the
   // pending-byte model, then the model advances across the next edge.
   task automatic applyStimulus();
      @(negedge clk);
      if (ackA && srcA.size() != 0) void'(srcA.pop_front());
      if (ackB && srcB.size() != 0) void'(srcB.pop_front());
      reqA  = (srcA.size() != 0);
      dataA = reqA ? srcA[0] : 8'($urandom);
      reqB  = (srcB.size() != 0);
      dataB = reqB ? srcB[0] : 16'($urandom);
      full  = randFull ? ($urandom_range(0, 3) == 0) : fullVal;
      #1;
      checkOutput("busy", busy, pend.size() != 0);
      checkOutput("w_inc", wInc, (pend.size() != 0) && !full);
      if (pend.size() != 0) checkOutput("wr_data", wrData, pend[0]);
      checkOutput("ack_a", ackA, expAckA);
      checkOutput("ack_b", ackB, expAckB);
      if (wInc) wrLog.push_back(wrData);
      expAckA = 1'b0;
      expAckB = 1'b0;
      if (pend.size() == 0) begin
         if (reqA && (!reqB || lastB)) begin
            pend.push_back(dataA);
            lastB   = 1'b0;
            expAckA = 1'b1;
         end else if (reqB) begin
            pend.push_back(dataB[7:0]);
            pend.push_back(dataB[15:8]);
            lastB   = 1'b1;
            expAckB = 1'b1;
         end
      end else if (!full) begin
         void'(pend.pop_front());
      end
      @(posedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      reqA = 1'b0;
      reqB = 1'b0;
      full = 1'b0;
      srcA.delete();
      srcB.delete();
      pend.delete();
      lastB = 1'b1;
      expAckA = 1'b0;
      expAckB = 1'b0;
      #1;
      checkOutput("rst_wr_data", wrData, 0);
      checkOutput("rst_ack_a", ackA, 0);
      checkOutput("rst_ack_b", ackB, 0);
      checkOutput("rst_w_inc", wInc, 0);
      checkOutput("rst_busy", busy, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic runUntilWrites(input string tag, input int n);
      for (int i = 0; i < 20 && wrLog.size() < n; i++) applyStimulus();
      checkOutput(tag, wrLog.size(), n);
   endtask

   initial begin
      doReset();

      srcA.push_back(8'h83);
      repeat (6) applyStimulus();
      expLog = '{8'h83};
      checkLog("single_a");

      srcB.push_back(16'hA55A);
      repeat (6) applyStimulus();
      expLog = '{8'h5A, 8'hA5};
      checkLog("single_b");

      doReset();
      srcA.push_back(8'h11);
      srcB.push_back(16'h3322);
      repeat (10) applyStimulus();
      srcA.push_back(8'h44);
      srcB.push_back(16'h6655);
      repeat (10) applyStimulus();
      expLog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      checkLog("tie");

      srcB.push_back(16'hC3D2);
      runUntilWrites("stall_reach_hi", 1);
      fullVal = 1'b1;
      repeat (5) applyStimulus();
      fullVal = 1'b0;
      repeat (4) applyStimulus();
      expLog = '{8'hD2, 8'hC3};
      checkLog("full_stall");

      srcB.push_back(16'hBEEF);
      runUntilWrites("midb_reach_hi", 1);
      doReset();
      srcA.push_back(8'h5C);
      repeat (5) applyStimulus();
      expLog = '{8'hEF, 8'h5C};
      checkLog("reset_mid_b");

      randFull = 1'b1;
      for (int c = 0; c < 800; c++) begin
         if (srcA.size() < 3 && $urandom_range(0, 3) == 0) srcA.push_back(8'($urandom));
         if (srcB.size() < 3 && $urandom_range(0, 3) == 0) srcB.push_back(16'($urandom));
         applyStimulus();
      end
      randFull = 1'b0;
      fullVal = 1'b0;
      repeat (30) applyStimulus();
      checkOutput("drain_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
